// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode map, FSM states and helpers for alu_seq
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SHL = 4'b0101,
        OP_SHR = 4'b0110,
        OP_MUL = 4'b0111,
        OP_DIV = 4'b1000,
        OP_MOD = 4'b1001
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXEC_1C = 3'd1,
        ST_MUL_IT  = 3'd2,
        ST_DIV_IT  = 3'd3,
        ST_DONE    = 3'd4
    } alu_state_e;

    // Ops that go through the n-cycle iterative core
    function automatic logic is_iterative(alu_op_e o);
        return (o == OP_MUL) || (o == OP_DIV) || (o == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// rtl/alu_iter_core.sv - shared shift-add multiplier / restoring divider, n iterations
module alu_iter_core #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_div,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         done,
    output logic [n-1:0] lo,
    output logic [n-1:0] hi
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;

    logic [CW-1:0] cnt;
    logic          busy;
    logic          div_q;
    logic [n-1:0]  acc;      // partial product high half / running remainder
    logic [n-1:0]  sr;       // multiplier bits shifting out / quotient bits shifting in
    logic [n-1:0]  bb;       // multiplicand / divisor
    logic [n:0]    add_sum;
    logic [n:0]    shifted;
    logic [n:0]    trial;

    // One step of each algorithm; only the one selected by div_q is committed
    always_comb begin
        add_sum = {1'b0, acc} + (sr[0] ? {1'b0, bb} : {(n+1){1'b0}});
        shifted = {acc, sr[n-1]};
        trial   = shifted - {1'b0, bb};
    end

    // Iteration registers; start reloads even if a previous run left done set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            div_q <= 1'b0;
            acc   <= '0;
            sr    <= '0;
            bb    <= '0;
        end else if (start) begin
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            div_q <= is_div;
            acc   <= '0;
            sr    <= a;
            bb    <= b;
        end else if (busy) begin
            if (div_q) begin
                // Trial subtraction is non-negative exactly when bit n is clear
                if (!trial[n]) begin
                    acc <= trial[n-1:0];
                    sr  <= {sr[n-2:0], 1'b1};
                end else begin
                    acc <= shifted[n-1:0];
                    sr  <= {sr[n-2:0], 1'b0};
                end
            end else begin
                {acc, sr} <= {add_sum, sr[n-1:1]};
            end
            if (cnt == CW'(n - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign lo = sr;
    assign hi = acc;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked multi-cycle ALU with iterative MUL/DIV and error flag
module alu_seq
    import alu_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [n-1:0] num1,
    input  logic [n-1:0] num2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] result,
    output logic [n-1:0] result_hi,
    output logic         Z,
    output logic         N,
    output logic         V,
    output logic         C,
    output logic         err
);

    localparam logic [n-1:0] SH_LIM = n[n-1:0];

    alu_state_e   state, state_nx;
    alu_op_e      op_in;
    alu_op_e      op_q;
    logic [n-1:0] a_q, b_q;
    logic         accept;
    logic         div_zero_in;
    logic         iter_start;
    logic         iter_done;
    logic [n-1:0] iter_lo, iter_hi;

    logic [n-1:0] res_d, hi_d;
    logic         v_d, c_d, err_d;
    logic [n:0]   sum_w, diff_w;

    assign op_in       = alu_op_e'(op);
    assign in_ready    = (state == ST_IDLE);
    assign accept      = in_valid && in_ready;
    assign div_zero_in = ((op_in == OP_DIV) || (op_in == OP_MOD)) && (num2 == '0);
    assign iter_start  = accept && is_iterative(op_in) && !div_zero_in;

    alu_iter_core #(.n(n)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (iter_start),
        .is_div (op_in != OP_MUL),
        .a      (num1),
        .b      (num2),
        .done   (iter_done),
        .lo     (iter_lo),
        .hi     (iter_hi)
    );

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!iter_start)
                        state_nx = ST_EXEC_1C;
                    else if (op_in == OP_MUL)
                        state_nx = ST_MUL_IT;
                    else
                        state_nx = ST_DIV_IT;
                end
            end
            ST_EXEC_1C: state_nx = ST_DONE;
            ST_MUL_IT:  if (iter_done) state_nx = ST_DONE;
            ST_DIV_IT:  if (iter_done) state_nx = ST_DONE;
            ST_DONE:    if (out_ready) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Result and carry/overflow/error for whichever op is finishing this cycle
    always_comb begin
        res_d  = '0;
        hi_d   = '0;
        v_d    = 1'b0;
        c_d    = 1'b0;
        err_d  = 1'b0;
        sum_w  = {1'b0, a_q} + {1'b0, b_q};
        diff_w = {1'b0, a_q} - {1'b0, b_q};
        case (state)
            ST_EXEC_1C: begin
                case (op_q)
                    OP_ADD: begin
                        res_d = sum_w[n-1:0];
                        c_d   = sum_w[n];
                        v_d   = (a_q[n-1] == b_q[n-1]) && (sum_w[n-1] != a_q[n-1]);
                    end
                    OP_SUB: begin
                        res_d = diff_w[n-1:0];
                        c_d   = diff_w[n];
                        v_d   = (a_q[n-1] != b_q[n-1]) && (diff_w[n-1] != a_q[n-1]);
                    end
                    OP_AND: res_d = a_q & b_q;
                    OP_OR:  res_d = a_q | b_q;
                    OP_XOR: res_d = a_q ^ b_q;
                    OP_SHL: res_d = (b_q >= SH_LIM) ? '0 : (a_q << b_q);
                    OP_SHR: res_d = (b_q >= SH_LIM) ? '0 : (a_q >> b_q);
                    // Only divide-by-zero reaches here for DIV/MOD
                    default: err_d = 1'b1;
                endcase
            end
            ST_MUL_IT: begin
                res_d = iter_lo;
                hi_d  = iter_hi;
                c_d   = (iter_hi != '0);
                v_d   = (iter_hi != '0);
            end
            ST_DIV_IT: begin
                if (op_q == OP_MOD) begin
                    res_d = iter_hi;
                    hi_d  = iter_lo;
                end else begin
                    res_d = iter_lo;
                    hi_d  = iter_hi;
                end
            end
            default: ;
        endcase
    end

    // State, operand latches and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            Z         <= 1'b0;
            N         <= 1'b0;
            V         <= 1'b0;
            C         <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= (state_nx == ST_DONE);
            if (accept) begin
                op_q <= op_in;
                a_q  <= num1;
                b_q  <= num2;
            end
            if ((state_nx == ST_DONE) && (state != ST_DONE)) begin
                result    <= res_d;
                result_hi <= hi_d;
                Z         <= (res_d == '0);
                N         <= res_d[n-1];
                V         <= v_d;
                C         <= c_d;
                err       <= err_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized and directed self-checking bench for alu_seq
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] num1, num2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result, result_hi;
    logic         Z, N, V, C, err;

    int checks = 0;
    int errors = 0;

    int e_res, e_hi, e_lat;
    logic e_z, e_n, e_v, e_c, e_err;

    alu_seq #(.n(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .num1      (num1),
        .num2      (num2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .Z         (Z),
        .N         (N),
        .V         (V),
        .C         (C),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's definition
    task automatic model(input int o, input int a, input int b);
        int s;
        e_res = 0; e_hi = 0; e_v = 0; e_c = 0; e_err = 0; e_lat = 1;
        case (o)
            0: begin
                s = a + b; e_res = s % 256; e_c = (s > 255);
                s = (a > 127 ? a - 256 : a) + (b > 127 ? b - 256 : b);
                e_v = (s > 127) || (s < -128);
            end
            1: begin
                e_res = (a - b + 256) % 256; e_c = (a < b);
                s = (a > 127 ? a - 256 : a) - (b > 127 ? b - 256 : b);
                e_v = (s > 127) || (s < -128);
            end
            2: e_res = a & b;
            3: e_res = a | b;
            4: e_res = a ^ b;
            5: e_res = (b >= W) ? 0 : ((a << b) % 256);
            6: e_res = (b >= W) ? 0 : (a >> b);
            7: begin
                s = a * b; e_res = s % 256; e_hi = s / 256;
                e_c = (e_hi != 0); e_v = e_c; e_lat = W + 1;
            end
            8, 9: begin
                if (b == 0) e_err = 1;
                else begin
                    e_lat = W + 1;
                    e_res = (o == 8) ? a / b : a % b;
                    e_hi  = (o == 8) ? a % b : a / b;
                end
            end
            default: e_err = 1;
        endcase
        e_z = (e_res == 0);
        e_n = (e_res >= 128);
    endtask

    // Issue one op, wait for its result, compare, then consume it
    task automatic run_op(input int o, input int a, input int b, input string tag);
        int lat;
        model(o, a, b);
        @(negedge clk);
        chk({tag, ".in_ready"}, in_ready, 1);
        in_valid = 1; op = 4'(o); num1 = 8'(a); num2 = 8'(b);
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, lat, e_lat);
        chk({tag, ".res"}, result, e_res);
        chk({tag, ".hi"}, result_hi, e_hi);
        chk({tag, ".zn_vc_err"}, {Z, N, V, C, err}, {e_z, e_n, e_v, e_c, e_err});
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk({tag, ".released"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [W-1:0] hold_res;
        logic [4:0]   hold_flags;
        int           seen;
        rst_n = 0; in_valid = 0; out_ready = 0; op = 0; num1 = 0; num2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.state", {in_ready, out_valid, result, result_hi, Z, N, V, C, err},
            {1'b1, 1'b0, 16'h0, 5'b0});
        rst_n = 1;

        run_op(0, 8'h7F, 8'h01, "add_ovf");
        run_op(1, 8'h03, 8'h05, "sub_borrow");
        run_op(5, 8'h01, 8'd9, "shl_big");
        run_op(6, 8'h80, 8'd7, "shr7");
        run_op(7, 8'h10, 8'h20, "mul");
        run_op(7, 8'hFF, 8'hFF, "mul_max");
        run_op(8, 200, 7, "div");
        run_op(9, 200, 7, "mod");
        run_op(8, 5, 0, "div0");
        run_op(9, 5, 0, "mod0");

        // Reset in the middle of a MUL aborts it and clears outputs
        @(negedge clk);
        in_valid = 1; op = 4'd7; num1 = 8'hFF; num2 = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        repeat (3) @(negedge clk);
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_mid.state", {in_ready, out_valid, result, result_hi, Z, N, V, C, err},
            {1'b1, 1'b0, 16'h0, 5'b0});
        rst_n = 1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("reset_mid.no_result", seen, 0);

        // Backpressure: results held, new requests refused
        model(0, 8'h55, 8'hC3);
        @(negedge clk);
        in_valid = 1; op = 4'd0; num1 = 8'h55; num2 = 8'hC3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        chk("bp.valid", out_valid, 1);
        hold_res = result;
        hold_flags = {Z, N, V, C, err};
        chk("bp.res", hold_res, e_res);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; op = 4'd2; num1 = 8'(i); num2 = 8'hFF;
            @(negedge clk);
            if (!(out_valid && !in_ready && result == hold_res && {Z, N, V, C, err} == hold_flags))
                seen++;
        end
        in_valid = 0;
        chk("bp.stable", seen, 0);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("bp.idle", {out_valid, in_ready}, 2'b01);
        @(negedge clk);
        chk("bp.no_accept", {out_valid, in_ready}, 2'b01);

        run_op(4'b1100, 8'h12, 8'h34, "illegal");

        for (int k = 0; k < 40; k++) begin
            int ro, ra, rb;
            ro = int'($urandom_range(0, 15));
            ra = int'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            if (ro == 5 || ro == 6) rb = int'($urandom_range(0, 10));
            run_op(ro, ra, rb, $sformatf("rnd%0d_op%0d", k, ro));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
